// File: rtl/cpu_io_ctrl.sv
// rtl/cpu_io_ctrl.sv - front-panel key debounce, HALT/STEP/RUN CPU stepping and LED latch
// Optional breakpoint halt in RUN: define CPUIO_BREAKPOINT_EN
module cpu_io_ctrl #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int DATA_WIDTH      = 32,
    parameter int LED_WIDTH       = 18
) (
    input  logic                  clock_50,
    input  logic                  reset,
    input  logic [N_KEYS-1:0]     key_n,
    output logic [N_KEYS-1:0]     key_pressed,
    output logic                  step_en,
    output logic                  run_active,
    input  logic                  led_we,
    input  logic                  led_sel,
    input  logic [DATA_WIDTH-1:0] led_data_a,
    input  logic [DATA_WIDTH-1:0] led_data_b,
`ifdef CPUIO_BREAKPOINT_EN
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] break_addr,
    input  logic                  break_valid,
    output logic                  break_hit,
`endif
    output logic [LED_WIDTH-1:0]  LEDR
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(RUN_DIV - 1);

    typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN} state_t;

    // Synchronisers carry the pressed polarity so their cleared value reads as released.
    logic [N_KEYS-1:0] r_sync1, r_sync2, r_kp, r_kp_d;
    logic [CW-1:0]     r_cnt [N_KEYS];

    state_t            r_state;
    logic [PW-1:0]     r_presc;
    logic              r_step_en, r_run_active;
    logic [LED_WIDTH-1:0] r_ledr;

    logic [N_KEYS-1:0] w_press;
    logic              w_step_ev, w_run_ev, w_fire;
    logic [PW-1:0]     w_presc_next;
    logic [DATA_WIDTH-1:0]           w_led_src;
    logic [DATA_WIDTH+LED_WIDTH-1:0] w_led_wide;
    logic              w_unused_led;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_kp    <= '0;
            r_kp_d  <= '0;
            for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;
            r_kp_d  <= r_kp;
            for (int i = 0; i < N_KEYS; i++) begin
                if (r_sync2[i] == r_kp[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_kp[i]  <= ~r_kp[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press      = r_kp & ~r_kp_d;
    assign w_step_ev    = w_press[0];
    assign w_run_ev     = w_press[1];
    assign w_presc_next = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    assign w_fire       = (w_presc_next == PRESC_MAX);

`ifdef CPUIO_BREAKPOINT_EN
    logic r_break_hit;
    logic w_brk;
    assign w_brk     = break_valid && (pc == break_addr);
    assign break_hit = r_break_hit;
`endif

    // step_en is decided one edge ahead so it is high exactly while presc == RUN_DIV-1.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state      <= S_HALT;
            r_presc      <= '0;
            r_step_en    <= 1'b0;
            r_run_active <= 1'b0;
`ifdef CPUIO_BREAKPOINT_EN
            r_break_hit  <= 1'b0;
`endif
        end else begin
`ifdef CPUIO_BREAKPOINT_EN
            if (w_step_ev || w_run_ev) r_break_hit <= 1'b0;
`endif
            case (r_state)
                S_HALT: begin
                    if (w_run_ev) begin
                        r_state      <= S_RUN;
                        r_presc      <= '0;
                        r_run_active <= 1'b1;
                        r_step_en    <= (RUN_DIV == 1);
                    end else if (w_step_ev) begin
                        r_state   <= S_STEP;
                        r_step_en <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_state   <= S_HALT;
                    r_step_en <= 1'b0;
                end
                S_RUN: begin
                    if (w_run_ev) begin
                        r_state      <= S_HALT;
                        r_presc      <= '0;
                        r_step_en    <= 1'b0;
                        r_run_active <= 1'b0;
                    end
`ifdef CPUIO_BREAKPOINT_EN
                    else if (w_fire && w_brk) begin
                        r_state      <= S_HALT;
                        r_presc      <= '0;
                        r_step_en    <= 1'b0;
                        r_run_active <= 1'b0;
                        r_break_hit  <= 1'b1;
                    end
`endif
                    else begin
                        r_presc   <= w_presc_next;
                        r_step_en <= w_fire;
                    end
                end
                default: begin
                    r_state      <= S_HALT;
                    r_step_en    <= 1'b0;
                    r_run_active <= 1'b0;
                end
            endcase
        end
    end

    assign w_led_src    = led_sel ? led_data_b : led_data_a;
    assign w_led_wide   = {{LED_WIDTH{1'b0}}, w_led_src};
    assign w_unused_led = ^w_led_wide[DATA_WIDTH+LED_WIDTH-1:LED_WIDTH];

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_ledr <= '0;
        end else if (r_step_en && led_we) begin
            r_ledr <= w_led_wide[LED_WIDTH-1:0];
        end
    end

    assign key_pressed = r_kp;
    assign step_en     = r_step_en;
    assign run_active  = r_run_active;
    assign LEDR        = r_ledr;

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// tb/tb_cpu_io_ctrl.sv - vector table, hand sequences and randomized model check for cpu_io_ctrl
module tb_cpu_io_ctrl;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 3;
    localparam int DW = 32;
    localparam int LW = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_pressed;
    logic          step_en, run_active;
    logic          led_we = 1'b0, led_sel = 1'b0;
    logic [DW-1:0] led_data_a = '0, led_data_b = '0;
    logic [LW-1:0] LEDR;
`ifdef CPUIO_BREAKPOINT_EN
    logic [DW-1:0] pc = 32'h8, break_addr = 32'h10;
    logic          break_valid = 1'b0;
    logic          break_hit;
`endif

    cpu_io_ctrl #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RUN_DIV(RD),
                  .DATA_WIDTH(DW), .LED_WIDTH(LW)) dut (
        .clock_50(clk), .reset(reset), .key_n(key_n), .key_pressed(key_pressed),
        .step_en(step_en), .run_active(run_active), .led_we(led_we), .led_sel(led_sel),
        .led_data_a(led_data_a), .led_data_b(led_data_b),
`ifdef CPUIO_BREAKPOINT_EN
        .pc(pc), .break_addr(break_addr), .break_valid(break_valid), .break_hit(break_hit),
`endif
        .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the bench's CPU stand-in advances pc on each enabled edge.
    task automatic tick();
`ifdef CPUIO_BREAKPOINT_EN
        logic se;
        se = step_en;
`endif
        @(posedge clk);
        #1;
`ifdef CPUIO_BREAKPOINT_EN
        if (se) pc = pc + 32'd4;
`endif
    endtask

    typedef struct {
        logic [3:0]  key_n;
        logic        we;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [3:0]  kp;
        logic        run;
        int          steps;
        logic [17:0] led;
    } vec_t;

    vec_t tbl[22];

    // Reference model: debounce as "last DB synchronised samples all differ", run pacing by elapsed cycles.
    typedef enum {M_HALTED, M_SINGLE, M_RUNNING} mode_t;
    mode_t      m_mode;
    logic [3:0] raw_q[$];
    logic [3:0] m_kp, m_kp_prev;
    logic       m_step, m_run;
    logic [17:0] m_led;
    int         m_run_cycles;

    task automatic model_reset();
        raw_q.delete();
        for (int i = 0; i < DB + 2; i++) raw_q.push_back(4'h0);
        m_kp = '0; m_kp_prev = '0; m_mode = M_HALTED;
        m_step = 1'b0; m_run = 1'b0; m_led = '0; m_run_cycles = 0;
    endtask

    task automatic model_edge();
        logic [3:0] ev, nkp, smp;
        logic       all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        ev = m_kp & ~m_kp_prev;
        raw_q.push_back(~key_n);
        if (raw_q.size() > DB + 2) void'(raw_q.pop_front());
        nkp = m_kp;
        for (int i = 0; i < NK; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                smp = raw_q[raw_q.size() - 3 - j];
                if (smp[i] == m_kp[i]) all_diff = 1'b0;
            end
            if (all_diff) nkp[i] = ~m_kp[i];
        end
        m_kp_prev = m_kp;
        m_kp = nkp;
        if (m_step && led_we) m_led = led_sel ? led_data_b[17:0] : led_data_a[17:0];
        case (m_mode)
            M_HALTED:  if (ev[1]) begin m_mode = M_RUNNING; m_run_cycles = 0; end
                       else if (ev[0]) m_mode = M_SINGLE;
            M_SINGLE:  m_mode = M_HALTED;
            M_RUNNING: if (ev[1]) m_mode = M_HALTED; else m_run_cycles++;
            default:   m_mode = M_HALTED;
        endcase
        m_run  = (m_mode == M_RUNNING);
        m_step = (m_mode == M_SINGLE) || (m_run && (m_run_cycles % RD == RD - 1));
    endtask

    initial begin
        int steps;
        int hold;

        tbl[0]  = '{4'b1110, 1'b0, 1'b0, 32'h0,        32'h0,        3,  4'b0000, 1'b0, 0,  18'h0};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0000, 1'b0, 0,  18'h0};
        tbl[2]  = '{4'b1110, 1'b1, 1'b1, 32'h12345678, 32'h0003FFFF, 5,  4'b0000, 1'b0, 0,  18'h0};
        tbl[3]  = '{4'b1110, 1'b1, 1'b1, 32'h12345678, 32'h0003FFFF, 1,  4'b0001, 1'b0, 0,  18'h0};
        tbl[4]  = '{4'b1110, 1'b1, 1'b1, 32'h12345678, 32'h0003FFFF, 1,  4'b0001, 1'b0, 1,  18'h0};
        tbl[5]  = '{4'b1110, 1'b1, 1'b1, 32'h12345678, 32'h0003FFFF, 10, 4'b0001, 1'b0, 0,  18'h3FFFF};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 32'h12345678, 32'h0003FFFF, 10, 4'b0000, 1'b0, 0,  18'h3FFFF};
        tbl[7]  = '{4'b1110, 1'b0, 1'b0, 32'hAAAAAAAA, 32'h0,        10, 4'b0001, 1'b0, 1,  18'h3FFFF};
        tbl[8]  = '{4'b1111, 1'b0, 1'b0, 32'hAAAAAAAA, 32'h0,        10, 4'b0000, 1'b0, 0,  18'h3FFFF};
        tbl[9]  = '{4'b1110, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        10, 4'b0001, 1'b0, 1,  18'h1BEEF};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0000, 1'b0, 0,  18'h1BEEF};
        tbl[11] = '{4'b1101, 1'b0, 1'b0, 32'h0,        32'h0,        7,  4'b0010, 1'b1, 0,  18'h1BEEF};
        tbl[12] = '{4'b1110, 1'b0, 1'b0, 32'h0,        32'h0,        30, 4'b0001, 1'b1, 10, 18'h1BEEF};
        tbl[13] = '{4'b1101, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0010, 1'b0, 2,  18'h1BEEF};
        tbl[14] = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0000, 1'b0, 0,  18'h1BEEF};
        tbl[15] = '{4'b1100, 1'b0, 1'b0, 32'h0,        32'h0,        7,  4'b0011, 1'b1, 0,  18'h1BEEF};
        tbl[16] = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        20, 4'b0000, 1'b1, 7,  18'h1BEEF};
        tbl[17] = '{4'b1101, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0010, 1'b0, 2,  18'h1BEEF};
        tbl[18] = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0000, 1'b0, 0,  18'h1BEEF};
        tbl[19] = '{4'b1011, 1'b0, 1'b0, 32'h0,        32'h0,        8,  4'b0100, 1'b0, 0,  18'h1BEEF};
        tbl[20] = '{4'b0111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b1000, 1'b0, 0,  18'h1BEEF};
        tbl[21] = '{4'b1111, 1'b0, 1'b0, 32'h0,        32'h0,        10, 4'b0000, 1'b0, 0,  18'h1BEEF};

        reset = 1'b1;
        repeat (3) tick();
        check("reset key_pressed", 32'(key_pressed), 32'h0);
        check("reset step_en", 32'(step_en), 32'h0);
        check("reset run_active", 32'(run_active), 32'h0);
        check("reset LEDR", 32'(LEDR), 32'h0);
`ifdef CPUIO_BREAKPOINT_EN
        check("reset break_hit", 32'(break_hit), 32'h0);
`endif
        reset = 1'b0;

        for (int r = 0; r < 22; r++) begin
            key_n = tbl[r].key_n; led_we = tbl[r].we; led_sel = tbl[r].sel;
            led_data_a = tbl[r].a; led_data_b = tbl[r].b;
            steps = 0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                tick();
                if (step_en) steps++;
            end
            check($sformatf("vec%0d key_pressed", r), 32'(key_pressed), 32'(tbl[r].kp));
            check($sformatf("vec%0d run_active", r), 32'(run_active), 32'(tbl[r].run));
            check($sformatf("vec%0d step_count", r), 32'(steps), 32'(tbl[r].steps));
            check($sformatf("vec%0d LEDR", r), 32'(LEDR), 32'(tbl[r].led));
        end

        // Reset in the middle of RUN clears LEDR and stops all stepping.
        key_n = 4'b1101;
        repeat (7) tick();
        check("midrun run_active", 32'(run_active), 32'h1);
        key_n = 4'b1111; reset = 1'b1;
        tick();
        check("midrun reset LEDR", 32'(LEDR), 32'h0);
        check("midrun reset run_active", 32'(run_active), 32'h0);
        check("midrun reset step_en", 32'(step_en), 32'h0);
        check("midrun reset key_pressed", 32'(key_pressed), 32'h0);
        reset = 1'b0;
        steps = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (step_en || run_active) steps++;
        end
        check("post reset idle", 32'(steps), 32'h0);

`ifdef CPUIO_BREAKPOINT_EN
        pc = 32'h8; break_addr = 32'h10; break_valid = 1'b1;
        key_n = 4'b1101;
        repeat (7) tick();
        check("brk run_active", 32'(run_active), 32'h1);
        key_n = 4'b1111;
        steps = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (step_en) steps++;
        end
        check("brk step_count", 32'(steps), 32'h2);
        check("brk run_active after", 32'(run_active), 32'h0);
        check("brk break_hit", 32'(break_hit), 32'h1);
        check("brk pc", pc, 32'h10);
        key_n = 4'b1110;
        steps = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (step_en) steps++;
        end
        check("brk single step", 32'(steps), 32'h1);
        check("brk break_hit cleared", 32'(break_hit), 32'h0);
        key_n = 4'b1111; break_valid = 1'b0;
        repeat (10) tick();
`endif

        reset = 1'b1;
        model_edge(); tick();
        model_edge(); tick();
        reset = 1'b0;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                key_n = 4'($urandom);
                hold  = $urandom_range(1, 9);
            end
            hold--;
            led_we     = 1'($urandom);
            led_sel    = 1'($urandom);
            led_data_a = $urandom;
            led_data_b = $urandom;
            reset      = ($urandom_range(0, 499) == 0);
            model_edge();
            tick();
            check("rand key_pressed", 32'(key_pressed), 32'(m_kp));
            check("rand step_en", 32'(step_en), 32'(m_step));
            check("rand run_active", 32'(run_active), 32'(m_run));
            check("rand LEDR", 32'(LEDR), 32'(m_led));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_io_ctrl.md
Name: cpu_io_ctrl

Overview:
Parametrised front-panel controller between board buttons/LEDs and the single-cycle CPU core. It debounces N_KEYS raw active-low push-buttons and runs a HALT/STEP/RUN state machine. The machine emits a one-cycle CPU clock-enable, `step_en`, in place of a button-derived clock. It also latches a selectable CPU data word onto the LED bank.

Parameters:
N_KEYS, 4, number of raw buttons; must be >= 2 (key 0 = step, key 1 = run/stop, the rest are debounced only)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change; must be >= 2
RUN_DIV, 25000000, clock_50 cycles per step_en pulse in RUN mode; must be >= 1
DATA_WIDTH, 32, width of CPU data inputs
LED_WIDTH, 18, width of LEDR

Ports:
clock_50  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
key_n  in  N_KEYS  raw buttons, active-low, asynchronous to clock_50
key_pressed  out  N_KEYS  debounced level per key, 1 = pressed
step_en  out  1  one-cycle CPU clock-enable pulse
run_active  out  1  1 while in RUN state
led_we  in  1  CPU LED-write control
led_sel  in  1  0 selects led_data_a, 1 selects led_data_b
led_data_a  in  DATA_WIDTH  LED source A (register port 1)
led_data_b  in  DATA_WIDTH  LED source B (register port 2)
LEDR  out  LED_WIDTH  LED register

Behaviour:
- Reset (synchronous, checked first every cycle):
  - state = HALT
  - step_en = 0, run_active = 0, LEDR = 0, key_pressed = 0
  - all debounce counters, synchronisers and the prescaler = 0
- Reset asserted mid-RUN or mid-debounce aborts everything. No step_en is issued in the reset cycle or the cycle after it.
- Synchronisation: each key_n bit passes through a 2-flop synchroniser; the sample is the inverted synchroniser output (1 = pressed).
- Debounce, per key:
  - cnt increments while sample != key_pressed, and clears when they are equal.
  - When cnt reaches DEBOUNCE_CYCLES-1 while still differing, key_pressed toggles and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
  - Total latency from a key_n edge to the key_pressed change = 2 + DEBOUNCE_CYCLES cycles.
- Press event: internal one-cycle pulse when key_pressed goes 0->1. Releases generate no event.
- FSM (registered):
  - HALT:
    - run event -> RUN, prescaler cleared.
    - Else step event -> STEP.
    - Both events in the same cycle: run wins; no step is issued.
  - STEP: step_en = 1 for exactly this one cycle, then -> HALT unconditionally. Events arriving in STEP are discarded.
  - RUN:
    - run_active = 1.
    - Prescaler counts 0..RUN_DIV-1 and wraps.
    - step_en = 1 in the cycle the prescaler equals RUN_DIV-1. With RUN_DIV = 1, step_en is high every RUN cycle.
    - run event -> HALT, prescaler cleared; no step_en in the exit cycle.
    - Step events are ignored.
- step_en is registered and therefore never asserted outside STEP/RUN.
- First step_en after a step press occurs 1 cycle after the press event.
- LED latch:
  - When step_en && led_we, LEDR <= (led_sel ? led_data_b : led_data_a), truncated to LED_WIDTH LSBs. If LED_WIDTH > DATA_WIDTH, the value is zero-extended.
  - Otherwise LEDR holds. led_we without step_en has no effect.
- Keys 2..N_KEYS-1 only drive key_pressed.

Optional Feature:
Macro CPUIO_BREAKPOINT_EN.
- Defined:
  - Adds ports `pc` (in, DATA_WIDTH), `break_addr` (in, DATA_WIDTH), `break_valid` (in, 1) and `break_hit` (out, 1, reset 0).
  - In RUN, if break_valid && pc == break_addr in a cycle where step_en would fire, step_en is suppressed, the FSM goes to HALT and break_hit is set.
  - break_hit clears on the next step or run event, or on reset.
  - Single STEP from HALT ignores the breakpoint.
- Not defined: these ports and all related logic are absent; RUN is stopped only by the run key or reset.

Test Plan:
1. DEBOUNCE_CYCLES=4: key_n[0] low for 3 cycles then high -> key_pressed[0] stays 0; no step_en.
2. key_n[0] held low 10 cycles -> key_pressed[0]=1 exactly 6 cycles after the fall; single step_en pulse 1 cycle after that; no further pulses while held.
3. RUN_DIV=3, press key 1 -> run_active=1; step_en pulses every 3rd cycle; key 0 presses have no effect; second key 1 press -> HALT, run_active=0, pulses stop.
4. HALT, keys 0 and 1 debounced in the same cycle -> RUN entered; no STEP pulse.
5. led_we=1, led_sel=1, led_data_b=32'h0003_FFFF, step pulse -> LEDR=18'h3FFFF. Then led_we=0 with a step -> LEDR unchanged. Reset asserted -> LEDR=0 next cycle.
6. CPUIO_BREAKPOINT_EN, RUN_DIV=2, break_addr=32'h10, pc ramps 8,C,10 -> step_en is suppressed at pc=10 and break_hit=1, HALT. A step press then gives one step_en and clears break_hit.
